prog_timer: RTL and testbench

Parametrised, pausable countdown timer that succeeds the single-mode alarm timer in the alarm controller. It loads a seconds value and counts it down with a configurable clocks-per-second prescaler. While running it emits one-second and half-second enable strobes, and it reports completion through `expired`. It adds pause, abort, restart, a remaining-seconds readout and optional auto-reload.

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_prescaler.sv | 47 ++++
 rtl/prog_timer.sv | 138 +++++++++++++
 tb/tb_prog_timer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable countdown timer.
package timer_pkg;

  localparam int unsigned TIMER_CPS_SIM   = 10;
  localparam int unsigned TIMER_CPS_BOARD = 100_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } timer_state_t;

  // Width of the sub-second prescaler for a given clocks-per-second rate.
  function automatic int unsigned sub_w(input int unsigned cps);
    return $clog2(cps);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Sub-second prescaler: counts CLK_PER_SEC-1 down to 0 and flags second and
// half-second boundaries. Clear beats load beats count.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = TIMER_CPS_SIM
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic count,
  output logic sec_tick,
  output logic half_tick
);

  localparam int unsigned     SUB_W    = sub_w(CLK_PER_SEC);
  localparam logic [SUB_W-1:0] SUB_TOP  = SUB_W'(CLK_PER_SEC - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(CLK_PER_SEC / 2);

  logic [SUB_W-1:0] sub;
  logic [SUB_W-1:0] sub_next;

  // Reaching zero wraps back to the top; the owner decides whether that ends a second.
  always_comb begin
    sub_next = sub;
    if (clear) begin
      sub_next = '0;
    end else if (load) begin
      sub_next = SUB_TOP;
    end else if (count) begin
      sub_next = (sub == '0) ? SUB_TOP : sub - SUB_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sub <= '0;
    end else begin
      sub <= sub_next;
    end
  end

  assign sec_tick  = (sub == '0);
  assign half_tick = (sub == '0) || (sub == SUB_HALF);

endmodule

// File: rtl/prog_timer.sv
// Pausable countdown timer with second/half-second strobes and expiry flag.
// Optional auto-reload on completion is enabled by PROG_TIMER_AUTO_RELOAD_EN.
module prog_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = TIMER_CPS_SIM,
  parameter int unsigned VALUE_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               start_timer,
  input  logic               pause,
  input  logic               abort,
`ifdef PROG_TIMER_AUTO_RELOAD_EN
  input  logic               auto_reload,
`endif
  output logic               busy,
  output logic [VALUE_W-1:0] remaining,
  output logic               expired,
  output logic               one_hz_enable,
  output logic               half_hz_enable
);

  timer_state_t       state;
  timer_state_t       state_next;
  logic [VALUE_W-1:0] remaining_next;
  logic               expired_next;
  logic               pre_load;
  logic               pre_clear;
  logic               pre_count;
  logic               sec_tick;
  logic               half_tick;

  timer_prescaler #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .load     (pre_load),
    .clear    (pre_clear),
    .count    (pre_count),
    .sec_tick (sec_tick),
    .half_tick(half_tick)
  );

`ifdef PROG_TIMER_AUTO_RELOAD_EN
  logic [VALUE_W-1:0] reload_val;

  // Every accepted start also arms the reload value for later completions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reload_val <= '0;
    end else if (start_timer && !abort) begin
      reload_val <= value;
    end
  end
`endif

  // Priority: abort, then start, then pause; counting happens on any unpaused cycle.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    expired_next   = expired;
    pre_load       = 1'b0;
    pre_clear      = 1'b0;
    pre_count      = 1'b0;

    if (abort) begin
      state_next     = IDLE;
      remaining_next = '0;
      expired_next   = 1'b0;
      pre_clear      = 1'b1;
    end else if (start_timer) begin
      if (value != '0) begin
        state_next     = RUNNING;
        remaining_next = value;
        expired_next   = 1'b0;
        pre_load       = 1'b1;
      end else begin
        state_next     = IDLE;
        remaining_next = '0;
        expired_next   = 1'b1;
        pre_clear      = 1'b1;
      end
    end else begin
      case (state)
        RUNNING, PAUSED: begin
          expired_next = 1'b0;
          if (pause) begin
            state_next = PAUSED;
          end else begin
            state_next = RUNNING;
            pre_count  = 1'b1;
            if (sec_tick && (remaining != '0)) begin
              remaining_next = remaining - VALUE_W'(1);
              if (remaining == VALUE_W'(1)) begin
                expired_next = 1'b1;
`ifdef PROG_TIMER_AUTO_RELOAD_EN
                if (auto_reload) begin
                  remaining_next = reload_val;
                  pre_load       = 1'b1;
                end else begin
                  state_next = IDLE;
                  pre_clear  = 1'b1;
                end
`else
                state_next = IDLE;
                pre_clear  = 1'b1;
`endif
              end
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      expired   <= expired_next;
    end
  end

  assign busy           = (state == RUNNING) || (state == PAUSED);
  assign one_hz_enable  = (state == RUNNING) && sec_tick;
  assign half_hz_enable = (state == RUNNING) && half_tick;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: table of timed scenarios plus
// hand-written sequences (reset, remaining readout, async reset, auto-reload).
module tb_prog_timer;

  localparam int unsigned CPS = 10;
  localparam int unsigned VW  = 4;
  localparam int          LEN = 200;

  logic          clock = 1'b0;
  logic          reset;
  logic [VW-1:0] value;
  logic          start_timer;
  logic          pause;
  logic          abort;
  logic          busy;
  logic [VW-1:0] remaining;
  logic          expired;
  logic          one_hz_enable;
  logic          half_hz_enable;
`ifdef PROG_TIMER_AUTO_RELOAD_EN
  logic          auto_reload;
`endif

  always #5 clock = ~clock;

  prog_timer #(
    .CLK_PER_SEC(CPS),
    .VALUE_W    (VW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .value         (value),
    .start_timer   (start_timer),
    .pause         (pause),
    .abort         (abort),
`ifdef PROG_TIMER_AUTO_RELOAD_EN
    .auto_reload   (auto_reload),
`endif
    .busy          (busy),
    .remaining     (remaining),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .half_hz_enable(half_hz_enable)
  );

  // Scenario: start at edge 0; optional pause window, abort edge, restart edge.
  typedef struct {
    int value;
    int pause_at;
    int pause_len;
    int abort_at;
    int restart_at;
    int restart_val;
    int rem0;
    int busy_cyc;
    int ones;
    int halves;
    int exp_edge;
    int fin_exp;
  } vec_t;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, actual=%0d", name, act);
      return;
    end
    e = sb.pop_front();
    if (e.name != name || e.val != act) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (queued as %s)", name, act, e.val, e.name);
    end
  endtask

  task automatic check_now(input string name, input int act, input int expv);
    push(name, expv);
    check(name, act);
  endtask

  task automatic cleanup();
    @(negedge clock);
    start_timer = 1'b0;
    pause       = 1'b0;
    abort       = 1'b1;
    @(negedge clock);
    abort       = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_n     = 0;
    int one_n      = 0;
    int half_n     = 0;
    int exp_edge   = -1;
    int paused_str = 0;
    int rem0       = -1;
    push("rem_after_start", v.rem0);
    push("busy_cycles", v.busy_cyc);
    push("one_hz_pulses", v.ones);
    push("half_hz_pulses", v.halves);
    push("expired_edge", v.exp_edge);
    push("strobes_while_paused", 0);
    push("final_remaining", 0);
    push("final_expired", v.fin_exp);
    for (int c = 0; c < LEN; c++) begin
      @(negedge clock);
      start_timer = (c == 0) || (c == v.restart_at);
      value       = (c == v.restart_at) ? VW'(v.restart_val) : VW'(v.value);
      pause       = (c >= v.pause_at) && (c < v.pause_at + v.pause_len);
      abort       = (c == v.abort_at);
      @(posedge clock);
      #1;
      if (c == 0) rem0 = int'(remaining);
      if (busy) busy_n++;
      if (one_hz_enable) one_n++;
      if (half_hz_enable) half_n++;
      if (pause && (one_hz_enable || half_hz_enable)) paused_str++;
      if (expired && exp_edge < 0) exp_edge = c;
    end
    $display("row %0d value=%0d: busy=%0d one=%0d half=%0d exp_edge=%0d", idx, v.value,
             busy_n, one_n, half_n, exp_edge);
    check("rem_after_start", rem0);
    check("busy_cycles", busy_n);
    check("one_hz_pulses", one_n);
    check("half_hz_pulses", half_n);
    check("expired_edge", exp_edge);
    check("strobes_while_paused", paused_str);
    check("final_remaining", int'(remaining));
    check("final_expired", int'(expired));
    cleanup();
  endtask

  vec_t vecs[8];

  initial begin
    int strobes;
    int busy_n;
    int samp_edges[7];
    int samp_rem[7];

    //            val pa  pl ab  rs  rv rem0 busy one half exp fin
    vecs[0] = '{3,  -1, 0, -1, -1, 0, 3,   30,  3,  6,   30,  1};
    vecs[1] = '{5,  12, 7, -1, -1, 0, 5,   57,  5,  10,  57,  1};
    vecs[2] = '{4,  -1, 0, 15, -1, 0, 4,   15,  1,  3,   -1,  0};
    vecs[3] = '{2,  -1, 0, -1, 13, 1, 2,   23,  2,  4,   23,  1};
    vecs[4] = '{0,  -1, 0, -1, -1, 0, 0,   0,   0,  0,   0,   1};
    vecs[5] = '{15, -1, 0, -1, -1, 0, 15,  150, 15, 30,  150, 1};
    vecs[6] = '{1,  -1, 0, 0,  -1, 0, 0,   0,   0,  0,   -1,  0};
    vecs[7] = '{1,  5,  3, -1, -1, 0, 1,   13,  1,  2,   13,  1};

    reset       = 1'b1;
    value       = '0;
    start_timer = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;
`ifdef PROG_TIMER_AUTO_RELOAD_EN
    auto_reload = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check_now("reset_busy", int'(busy), 0);
    check_now("reset_remaining", int'(remaining), 0);
    check_now("reset_expired", int'(expired), 0);
    check_now("reset_one_hz", int'(one_hz_enable), 0);
    check_now("reset_half_hz", int'(half_hz_enable), 0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Remaining readout steps once per second, last 1 Hz strobe just before expiry.
    samp_edges = '{0, 9, 10, 19, 20, 29, 30};
    samp_rem   = '{3, 3, 2, 2, 1, 1, 0};
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      start_timer = (c == 0);
      value       = VW'(3);
      @(posedge clock);
      #1;
      for (int k = 0; k < 7; k++) begin
        if (samp_edges[k] == c) check_now("remaining_step", int'(remaining), samp_rem[k]);
      end
      if (c == 29) begin
        check_now("last_one_hz", int'(one_hz_enable), 1);
        check_now("expired_before_end", int'(expired), 0);
      end
    end
    cleanup();

    // Asynchronous reset mid-count drops outputs before any clock edge.
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      start_timer = (c == 0);
      value       = VW'(5);
    end
    start_timer = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset_busy", int'(busy), 0);
    check_now("async_reset_remaining", int'(remaining), 0);
    @(negedge clock);
    reset   = 1'b0;
    strobes = 0;
    busy_n  = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (one_hz_enable || half_hz_enable) strobes++;
      if (busy) busy_n++;
    end
    check_now("strobes_after_reset", strobes, 0);
    check_now("busy_after_reset", busy_n, 0);

`ifdef PROG_TIMER_AUTO_RELOAD_EN
    begin
      int exp_n = 0;
      int first = -1;
      int second = -1;
      busy_n = 0;
      auto_reload = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clock);
        start_timer = (c == 0);
        value       = VW'(2);
        abort       = (c == 45);
        @(posedge clock);
        #1;
        if (busy) busy_n++;
        if (expired) begin
          exp_n++;
          if (first < 0) first = c;
          else if (second < 0) second = c;
        end
      end
      check_now("reload_expired_cycles", exp_n, 2);
      check_now("reload_first_expiry", first, 20);
      check_now("reload_second_expiry", second, 40);
      check_now("reload_busy_cycles", busy_n, 45);
      auto_reload = 1'b0;
      cleanup();
    end
`endif

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: actual=%0d entries expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
